// File: rtl/sc_neuron_sched_if.sv
// Request, datapath-control and result signals between the layer controller,
// the APC neuron / SNG datapath and the neuron window sequencer.
interface sc_neuron_sched_if #(
    parameter int CW = 10
);
    logic          start_valid;
    logic          start_ready;
    logic [CW-1:0] win_len;
    logic          abort;
    logic          sng_load;
    logic          neuron_rst;
    logic          sng_en;
    logic          neuron_dout;
    logic          res_valid;
    logic          res_ready;
    logic [CW-1:0] res_count;
    logic          busy;

    modport slave (
        input  start_valid, win_len, abort, neuron_dout, res_ready,
        output start_ready, sng_load, neuron_rst, sng_en, res_valid, res_count, busy
    );

    modport master (
        output start_valid, win_len, abort, neuron_dout, res_ready,
        input  start_ready, sng_load, neuron_rst, sng_en, res_valid, res_count, busy
    );
endinterface

// File: rtl/sc_neuron_sched.sv
// Evaluation-window sequencer for one stochastic-computing APC neuron:
// load SNGs, clear neuron, warm up, count ones for win_len cycles, return count.
module sc_neuron_sched #(
    parameter int CW   = 10,
    parameter int WARM = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    sc_neuron_sched_if.slave   nif
);
    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, WARMUP, RUN, DONE} state_e;

    state_e        state_q;
    logic [CW-1:0] win_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] res_count_q;
    logic          sng_load_q;
    logic          neuron_rst_q;
    logic          sng_en_q;
    logic          res_valid_q;
    logic          accept;

    assign nif.start_ready = (state_q == IDLE) && !nif.abort;
    assign accept          = nif.start_valid && nif.start_ready;

    assign nif.sng_load   = sng_load_q;
    assign nif.neuron_rst = neuron_rst_q;
    assign nif.sng_en     = sng_en_q;
    assign nif.res_valid  = res_valid_q;
    assign nif.res_count  = res_count_q;
    assign nif.busy       = (state_q != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            win_q        <= '0;
            cnt_q        <= '0;
            res_count_q  <= '0;
            sng_load_q   <= 1'b0;
            neuron_rst_q <= 1'b0;
            sng_en_q     <= 1'b0;
            res_valid_q  <= 1'b0;
        end else if (nif.abort && state_q != IDLE) begin
            // Drop the window; the partial count stays visible but is never flagged valid.
            state_q      <= IDLE;
            sng_load_q   <= 1'b0;
            neuron_rst_q <= 1'b0;
            sng_en_q     <= 1'b0;
            res_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        win_q       <= nif.win_len;
                        res_count_q <= '0;
                        if (nif.win_len == '0) begin
                            state_q     <= DONE;
                            res_valid_q <= 1'b1;
                        end else begin
                            state_q    <= LOAD;
                            sng_load_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state_q      <= CLEAR;
                    sng_load_q   <= 1'b0;
                    neuron_rst_q <= 1'b1;
                end
                CLEAR: begin
                    neuron_rst_q <= 1'b0;
                    sng_en_q     <= 1'b1;
                    if (WARM == 0) begin
                        state_q <= RUN;
                        cnt_q   <= win_q;
                    end else begin
                        state_q <= WARMUP;
                        cnt_q   <= CW'(WARM);
                    end
                end
                WARMUP: begin
                    if (cnt_q == CW'(1)) begin
                        state_q <= RUN;
                        cnt_q   <= win_q;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RUN: begin
                    // One trailing cycle with sng_en low closes the window before
                    // the count is presented.
                    if (sng_en_q) begin
                        res_count_q <= res_count_q + {{(CW-1){1'b0}}, nif.neuron_dout};
                        cnt_q       <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) sng_en_q <= 1'b0;
                    end else begin
                        state_q     <= DONE;
                        res_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (nif.res_ready) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sc_neuron_sched.sv
// Randomized self-checking bench for sc_neuron_sched against a window-level
// model: expected count is the sum of driven RUN bits, timing from the window schedule.
module tb_sc_neuron_sched;
    localparam int CW   = 10;
    localparam int WARM = 4;

    logic gclk   = 1'b0;
    logic grst_n = 1'b1;
    always #5 gclk = ~gclk;

    sc_neuron_sched_if #(.CW(CW)) nif ();

    sc_neuron_sched #(.CW(CW), .WARM(WARM)) dut (
        .clk_i  (gclk),
        .rst_ni (grst_n),
        .nif    (nif.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge gclk);
        #1;
    endtask

    function automatic logic [31:0] outs_all();
        return {16'(nif.res_count), 11'd0, nif.res_valid, nif.sng_load,
                nif.neuron_rst, nif.sng_en, nif.busy};
    endfunction

    // pat: 0 all ones, 1 toggling starting at 1, 2 all zeros, other random
    task automatic run_txn(input int L, input int pat, input int hold);
        int bits[$];
        int exp_cnt = 0;
        int en_n = 0, ld_n = 0, rs_n = 0, ovl = 0, early = 0;
        int v, b, k;
        for (int i = 0; i < L; i++) begin
            case (pat)
                0:       b = 1;
                1:       b = (i % 2 == 0) ? 1 : 0;
                2:       b = 0;
                default: b = int'($urandom_range(0, 1));
            endcase
            bits.push_back(b);
            exp_cnt += b;
        end
        // accept at edge 0; LOAD, CLEAR, WARM warm-up and L run cycles, then valid
        v = (L == 0) ? 0 : 3 + WARM + L;
        nif.start_valid = 1'b1;
        nif.win_len     = CW'(L);
        #1 chk("start_ready", nif.start_ready, 1);
        step();
        nif.start_valid = 1'b0;
        for (int c = 0; c <= v; c++) begin
            en_n += nif.sng_en;
            ld_n += nif.sng_load;
            rs_n += nif.neuron_rst;
            if ((nif.sng_en && nif.neuron_rst) || (nif.sng_en && nif.sng_load)) ovl++;
            if (c < v && nif.res_valid) early++;
            if (c < v) begin
                k = c - 2 - WARM;
                nif.neuron_dout = (k >= 0 && k < L) ? bits[k][0] : 1'($urandom_range(0, 1));
                step();
            end
        end
        chk("res_valid", nif.res_valid, 1);
        chk("res_count", nif.res_count, exp_cnt);
        chk("early_valid", early, 0);
        chk("sng_en_cycles", en_n, (L == 0) ? 0 : WARM + L);
        chk("sng_load_pulses", ld_n, (L == 0) ? 0 : 1);
        chk("neuron_rst_pulses", rs_n, (L == 0) ? 0 : 1);
        chk("overlap", ovl, 0);
        nif.res_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            nif.neuron_dout = 1'($urandom_range(0, 1));
            step();
            chk("hold", {nif.res_valid, nif.busy, nif.start_ready, 16'(nif.res_count)},
                {1'b1, 1'b1, 1'b0, 16'(exp_cnt)});
        end
        nif.res_ready = 1'b1;
        step();
        nif.res_ready = 1'b0;
        chk("released", {nif.res_valid, nif.busy, nif.start_ready}, 3'b001);
    endtask

    initial begin
        int early;
        nif.start_valid = 1'b0;
        nif.win_len     = '0;
        nif.abort       = 1'b0;
        nif.neuron_dout = 1'b0;
        nif.res_ready   = 1'b0;
        #1 grst_n = 1'b0;
        #3 chk("reset_outs", outs_all(), 0);
        repeat (2) @(posedge gclk);
        #1 grst_n = 1'b1;
        #1 chk("post_reset", {nif.start_ready, nif.busy}, 2'b10);

        run_txn(16, 0, 0);   // 23-cycle latency, 20 sng_en cycles
        run_txn(9, 1, 0);    // toggling -> 5
        run_txn(9, 2, 0);    // zeros -> 0
        run_txn(12, 3, 10);  // back-pressure in DONE
        run_txn(0, 0, 2);    // empty window

        // abort while idle blocks accept
        nif.abort = 1'b1;
        nif.start_valid = 1'b1;
        nif.win_len = CW'(5);
        #1 chk("abort_idle_ready", nif.start_ready, 0);
        step();
        chk("abort_idle_busy", nif.busy, 0);
        nif.abort = 1'b0;
        nif.start_valid = 1'b0;

        // abort on the fifth RUN cycle of a 100-cycle window
        nif.start_valid = 1'b1;
        nif.win_len = CW'(100);
        step();
        nif.start_valid = 1'b0;
        nif.neuron_dout = 1'b1;
        for (int c = 0; c < 2 + WARM + 4; c++) step();
        nif.abort = 1'b1;
        step();
        nif.abort = 1'b0;
        chk("abort_outs", {nif.busy, nif.sng_en, nif.res_valid, nif.sng_load, nif.neuron_rst}, 0);
        #1 chk("abort_start_ready", nif.start_ready, 1);
        early = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            early += nif.res_valid;
        end
        chk("abort_no_result", early, 0);
        run_txn(3, 0, 0);

        for (int t = 0; t < 6; t++)
            run_txn(int'($urandom_range(1, 40)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

        // asynchronous reset in the middle of RUN
        nif.start_valid = 1'b1;
        nif.win_len = CW'(50);
        step();
        nif.start_valid = 1'b0;
        nif.neuron_dout = 1'b1;
        for (int c = 0; c < 2 + WARM + 6; c++) step();
        chk("mid_run_busy", {nif.busy, nif.sng_en}, 2'b11);
        #2 grst_n = 1'b0;
        #1 chk("async_reset_outs", outs_all(), 0);
        step();
        grst_n = 1'b1;
        #1 chk("after_reset", {nif.start_ready, nif.busy}, 2'b10);
        run_txn(7, 3, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
